// File: rtl/aes_round_if.sv
// aes_round_if: valid/ready request and response channel of the AES round datapath
interface aes_round_if #(
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [127:0]     in_state;
    logic [127:0]     in_key;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [127:0]     out_state;
    logic [TAG_W-1:0] out_tag;
    modport master (
        output in_valid, in_state, in_key, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_state, out_tag
    );
    modport slave (
        input  in_valid, in_state, in_key, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_state, out_tag
    );
endinterface

// File: rtl/aes_round_pipe.sv
// aes_round_pipe: one AES encryption round per transaction (FULL / LAST / KEY_ONLY)
// behind a valid/ready handshake, with one or two register stages.
module aes_round_pipe #(
    parameter int STAGES = 1,
    parameter int TAG_W  = 4
) (
    input logic        clk,
    input logic        rst_n,
    input logic        flush,
    aes_round_if.slave bus
);
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = b[i] ? p ^ x : p;
            x = xt(x);
        end
        return p;
    endfunction

    // S-box as GF(2^8) inverse (x^254, zero maps to zero) followed by the affine map
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s, r;
        s = x;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            s = gmul(s, s);
            r = gmul(r, s);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(x[8*k +: 8]);
        return o;
    endfunction

    // byte r+4c sits at [127-8(r+4c) -: 8]; row r rotates left by r columns
    function automatic logic [127:0] shift_rows(input logic [127:0] x);
        logic [127:0] o;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                o[127-8*(r+4*c) -: 8] = x[127-8*(r+4*((c+r)%4)) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x);
        logic [127:0] o;
        logic [7:0]   b0, b1, b2, b3;
        for (int c = 0; c < 4; c++) begin
            b0 = x[127-32*c -: 8];
            b1 = x[119-32*c -: 8];
            b2 = x[111-32*c -: 8];
            b3 = x[103-32*c -: 8];
            o[127-32*c -: 8] = xt(b0) ^ xt(b1) ^ b1 ^ b2 ^ b3;
            o[119-32*c -: 8] = b0 ^ xt(b1) ^ xt(b2) ^ b2 ^ b3;
            o[111-32*c -: 8] = b0 ^ b1 ^ xt(b2) ^ xt(b3) ^ b3;
            o[103-32*c -: 8] = xt(b0) ^ b0 ^ b1 ^ b2 ^ xt(b3);
        end
        return o;
    endfunction

    // modes 2 and 3 both skip the S-box and everything after it
    function automatic logic [127:0] pre(input logic [1:0] m, input logic [127:0] x);
        return m[1] ? x : sub_bytes(x);
    endfunction

    function automatic logic [127:0] post(input logic [1:0] m, input logic [127:0] x);
        return m == 2'd0 ? mix_columns(shift_rows(x)) : m == 2'd1 ? shift_rows(x) : x;
    endfunction

    logic [127:0] a;
    assign a = bus.in_state ^ bus.in_key;

    generate
        if (STAGES == 2) begin : g_two
            logic             v0, v1, ld0, ld1;
            logic [127:0]     d0, d1;
            logic [1:0]       m0;
            logic [TAG_W-1:0] t0, t1;
            assign ld1 = !v1 || bus.out_ready;
            assign ld0 = !v0 || ld1;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || flush) begin
                    v0 <= 1'b0;
                    v1 <= 1'b0;
                    d0 <= '0;
                    d1 <= '0;
                    m0 <= '0;
                    t0 <= '0;
                    t1 <= '0;
                end else begin
                    if (ld0) v0 <= bus.in_valid;
                    if (ld0 && bus.in_valid) begin
                        d0 <= pre(bus.in_mode, a);
                        m0 <= bus.in_mode;
                        t0 <= bus.in_tag;
                    end
                    if (ld1) v1 <= v0;
                    if (ld1 && v0) begin
                        d1 <= post(m0, d0);
                        t1 <= t0;
                    end
                end
            end
            assign bus.in_ready  = ld0;
            assign bus.out_valid = v1;
            assign bus.out_state = d1;
            assign bus.out_tag   = t1;
        end else begin : g_one
            logic             v, ld;
            logic [127:0]     d;
            logic [TAG_W-1:0] t;
            assign ld = !v || bus.out_ready;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n || flush) begin
                    v <= 1'b0;
                    d <= '0;
                    t <= '0;
                end else begin
                    if (ld) v <= bus.in_valid;
                    if (ld && bus.in_valid) begin
                        d <= post(bus.in_mode, pre(bus.in_mode, a));
                        t <= bus.in_tag;
                    end
                end
            end
            assign bus.in_ready  = ld;
            assign bus.out_valid = v;
            assign bus.out_state = d;
            assign bus.out_tag   = t;
        end
    endgenerate
endmodule

// File: tb/tb_aes_round_pipe.sv
// tb_aes_round_pipe: directed vectors against a 1-stage and a 2-stage instance side by side
module tb_aes_round_pipe;
    typedef struct {
        logic [127:0] st;
        logic [127:0] key;
        logic [1:0]   mode;
        logic [3:0]   tag;
        logic [127:0] res;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic flush = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;
    vec_t tv [9];

    aes_round_if #(.TAG_W(4)) i1 ();
    aes_round_if #(.TAG_W(4)) i2 ();

    aes_round_pipe #(.STAGES(1), .TAG_W(4)) d1 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i1.slave));
    aes_round_pipe #(.STAGES(2), .TAG_W(4)) d2 (.clk(clk), .rst_n(rst_n), .flush(flush), .bus(i2.slave));

    always #5 clk = ~clk;

    task automatic chk_bit(input string nm, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", nm, act, exp);
        end
    endtask

    task automatic chk_st(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_tag(input string nm, input logic [3:0] act, input logic [3:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic v, input vec_t t, input logic [3:0] tag);
        i1.in_valid = v;
        i2.in_valid = v;
        i1.in_state = t.st;
        i2.in_state = t.st;
        i1.in_key   = t.key;
        i2.in_key   = t.key;
        i1.in_mode  = t.mode;
        i2.in_mode  = t.mode;
        i1.in_tag   = tag;
        i2.in_tag   = tag;
    endtask

    task automatic set_ready(input logic r);
        i1.out_ready = r;
        i2.out_ready = r;
    endtask

    // one isolated transaction: result on d1 after one edge, on d2 after two
    task automatic run_vec(input string nm, input vec_t t);
        drive(1'b1, t, t.tag);
        @(negedge clk);
        drive(1'b0, t, t.tag);
        chk_bit({nm, " d1 valid"}, i1.out_valid, 1'b1);
        chk_st({nm, " d1 state"}, i1.out_state, t.res);
        chk_tag({nm, " d1 tag"}, i1.out_tag, t.tag);
        chk_bit({nm, " d2 early valid"}, i2.out_valid, 1'b0);
        @(negedge clk);
        chk_bit({nm, " d2 valid"}, i2.out_valid, 1'b1);
        chk_st({nm, " d2 state"}, i2.out_state, t.res);
        chk_tag({nm, " d2 tag"}, i2.out_tag, t.tag);
        chk_bit({nm, " d1 bubble"}, i1.out_valid, 1'b0);
    endtask

    initial begin
        tv[0] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 2'd0, 4'h5,
                  128'h5f72641557f5bc92f7be3b291db9f91a};
        tv[1] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 2'd1, 4'h6,
                  128'h6353e08c0960e104cd70b751bacad0e7};
        tv[2] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 2'd2, 4'h7,
                  128'h00102030405060708090a0b0c0d0e0f0};
        tv[3] = '{128'h00112233445566778899aabbccddeeff, 128'h000102030405060708090a0b0c0d0e0f, 2'd3, 4'h8,
                  128'h00102030405060708090a0b0c0d0e0f0};
        tv[4] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 2'd0, 4'h9,
                  128'h046681e5e0cb199a48f8d37a2806264c};
        tv[5] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 2'd1, 4'ha,
                  128'h d4bf5d30e0b452aeb84111f11e2798e5};
        tv[6] = '{128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c, 2'd2, 4'hb,
                  128'h193de3bea0f4e22b9ac68d2ae9f84808};
        tv[7] = '{128'h0, 128'h0, 2'd0, 4'h0, {16{8'h63}}};
        tv[8] = '{{16{8'h01}}, 128'h0, 2'd1, 4'hc, {16{8'h7c}}};
        drive(1'b0, tv[0], 4'h0);
        set_ready(1'b1);
        @(negedge clk);
        chk_bit("reset d1 valid", i1.out_valid, 1'b0);
        chk_st("reset d1 state", i1.out_state, 128'h0);
        chk_tag("reset d1 tag", i1.out_tag, 4'h0);
        chk_bit("reset d1 ready", i1.in_ready, 1'b1);
        chk_bit("reset d2 valid", i2.out_valid, 1'b0);
        chk_st("reset d2 state", i2.out_state, 128'h0);
        chk_bit("reset d2 ready", i2.in_ready, 1'b1);
        rst_n = 1'b1;
        for (int i = 0; i < 9; i++) run_vec($sformatf("vec%0d", i), tv[i]);
        // back-to-back stream, tags 0..7
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, tv[k], 4'(k));
            else drive(1'b0, tv[0], 4'h0);
            chk_bit($sformatf("stream%0d d2 ready", k), i2.in_ready, 1'b1);
            @(negedge clk);
            if (k < 8) chk_st($sformatf("stream%0d d1 state", k), i1.out_state, tv[k].res);
            chk_bit($sformatf("stream%0d d2 valid", k), i2.out_valid, k >= 1 && k <= 8);
            if (k >= 1 && k <= 8) begin
                chk_st($sformatf("stream%0d d2 state", k), i2.out_state, tv[k-1].res);
                chk_tag($sformatf("stream%0d d2 tag", k), i2.out_tag, 4'(k - 1));
            end
        end
        // backpressure: two accepts, then stall with stable output
        set_ready(1'b0);
        drive(1'b1, tv[4], 4'h1);
        chk_bit("bp ready0", i2.in_ready, 1'b1);
        @(negedge clk);
        chk_bit("bp ready1", i2.in_ready, 1'b1);
        chk_bit("bp valid1", i2.out_valid, 1'b0);
        drive(1'b1, tv[5], 4'h2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk_bit($sformatf("bp hold%0d valid", k), i2.out_valid, 1'b1);
            chk_st($sformatf("bp hold%0d state", k), i2.out_state, tv[4].res);
            chk_tag($sformatf("bp hold%0d tag", k), i2.out_tag, 4'h1);
            chk_bit($sformatf("bp hold%0d ready", k), i2.in_ready, 1'b0);
            drive(1'b1, tv[6], 4'h3);
        end
        drive(1'b0, tv[0], 4'h0);
        set_ready(1'b1);
        @(negedge clk);
        chk_bit("bp rel valid", i2.out_valid, 1'b1);
        chk_st("bp rel state", i2.out_state, tv[5].res);
        chk_tag("bp rel tag", i2.out_tag, 4'h2);
        @(negedge clk);
        chk_bit("bp drained", i2.out_valid, 1'b0);
        // flush with the pipe full and a concurrent input
        set_ready(1'b0);
        drive(1'b1, tv[0], 4'h1);
        @(negedge clk);
        drive(1'b1, tv[1], 4'h2);
        @(negedge clk);
        chk_bit("fl full valid", i2.out_valid, 1'b1);
        chk_bit("fl full ready", i2.in_ready, 1'b0);
        flush = 1'b1;
        drive(1'b1, tv[2], 4'h3);
        set_ready(1'b1);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, tv[0], 4'h0);
        chk_bit("fl d2 valid", i2.out_valid, 1'b0);
        chk_st("fl d2 state", i2.out_state, 128'h0);
        chk_tag("fl d2 tag", i2.out_tag, 4'h0);
        chk_bit("fl d1 valid", i1.out_valid, 1'b0);
        chk_st("fl d1 state", i1.out_state, 128'h0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk_bit($sformatf("fl after%0d d2 valid", k), i2.out_valid, 1'b0);
            chk_bit($sformatf("fl after%0d d1 valid", k), i1.out_valid, 1'b0);
        end
        // asynchronous reset mid-stream
        drive(1'b1, tv[4], 4'h4);
        @(negedge clk);
        drive(1'b1, tv[5], 4'h5);
        @(negedge clk);
        chk_bit("rst pre d2 valid", i2.out_valid, 1'b1);
        chk_bit("rst pre d1 valid", i1.out_valid, 1'b1);
        #2 rst_n = 1'b0;
        drive(1'b0, tv[0], 4'h0);
        #1;
        chk_bit("rst async d1 valid", i1.out_valid, 1'b0);
        chk_st("rst async d1 state", i1.out_state, 128'h0);
        chk_bit("rst async d2 valid", i2.out_valid, 1'b0);
        chk_st("rst async d2 state", i2.out_state, 128'h0);
        chk_tag("rst async d2 tag", i2.out_tag, 4'h0);
        chk_bit("rst async d2 ready", i2.in_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        run_vec("post_rst0", tv[6]);
        run_vec("post_rst1", tv[0]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/aes_round_pipe.md
Name: aes_round_pipe

Overview:
- Parametrised, pipelined successor to the combinational AES encrypt round.
- Applies one AES encryption round per transaction to a 128-bit state with a 128-bit round key: AddRoundKey, then SubBytes, ShiftRows and MixColumns, in that order.
- Adds mode selection (full / last / key-only), a valid/ready handshake with backpressure, configurable pipeline depth, a passthrough tag and a flush.
- Sits between the round controller and the key schedule; it is the datapath for iterative or unrolled encryption.

Parameters:
- STAGES, 1, register stages (1 or 2). 1: one register at the output. 2: an extra register after SubBytes.
- TAG_W, 4, width of the sideband tag carried alongside the state (minimum 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; clears all pipeline valids
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- in_state  in  128  state; [127:120] = byte s0,0, column-major per FIPS-197
- in_key  in  128  round key, same byte order as in_state
- in_mode  in  2  0 FULL, 1 LAST, 2 KEY_ONLY, 3 reserved (treated as KEY_ONLY)
- in_tag  in  TAG_W  opaque tag, returned unchanged
- out_valid  out  1  output transaction valid
- out_ready  in  1  downstream accepts the output
- out_state  out  128  round result
- out_tag  out  TAG_W  tag of the output transaction

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous, active-low. While rst_n is low, every stage valid, out_state and out_tag are 0. in_ready is combinational from the stage valids and is therefore 1 during reset.
- Datapath per mode:
  - a = in_state ^ in_key.
  - FULL = MixColumns(ShiftRows(SubBytes(a))).
  - LAST = ShiftRows(SubBytes(a)).
  - KEY_ONLY = a.
  - The mode travels with the data when STAGES=2.
- STAGES=1: the output register captures the full result. Latency is 1 cycle from the accepting edge to out_valid.
- STAGES=2:
  - Stage 0 registers the SubBytes result (or a, for KEY_ONLY), plus mode and tag.
  - Stage 1 applies ShiftRows and MixColumns as the mode requires.
  - Latency is 2 cycles.
- Handshake:
  - An input transfer occurs when in_valid && in_ready.
  - An output transfer occurs when out_valid && out_ready.
  - Stage i loads when its valid is 0, or when the next stage (or the output port, for the last stage) transfers in the same cycle. in_ready equals the load condition of stage 0.
  - Full throughput: one transaction per cycle while out_ready=1.
- Backpressure: with out_ready=0 the stages fill, then in_ready drops. Held out_state and out_tag must not change while out_valid=1 and out_ready=0.
- Simultaneous events:
  - Input and output transfers in the same cycle on a full pipe shift data through with no bubble.
  - flush has priority over any transfer. In the cycle after flush is high, all valids are 0 and data registers are zeroed, so no residual state is left.
  - An input presented while flush is high is dropped.
- Bubbles: a stage that does not load keeps its valid low. No stage ever duplicates data.
- Reset mid-operation: all in-flight transactions are discarded immediately and outputs are zeroed.
- No internal state beyond the pipeline registers. The S-box is combinational in the same cycle.

Test Plan:
- FULL, STAGES=1: in_state=00112233445566778899aabbccddeeff, in_key=000102030405060708090a0b0c0d0e0f, tag=5 -> one cycle later out_state=5f72641557f5bc92f7be3b291db9f91a, out_tag=5.
- LAST, same inputs -> out_state=6353e08c0960e104cd70b751bacad0e7. KEY_ONLY, same inputs -> out_state=00102030405060708090a0b0c0d0e0f0.
- STAGES=2: stream 8 back-to-back transactions of mixed modes and tags 0..7 with out_ready=1 -> outputs appear in order, latency 2, one per cycle, results match the per-mode reference model.
- Backpressure: STAGES=2, out_ready=0 for 5 cycles while in_valid=1 -> in_ready falls after 2 accepts, out_state/out_tag stable. Release -> both transactions delivered, none lost or duplicated.
- Flush with the pipe full and in_valid=1 -> next cycle out_valid=0 and out_state=0; the flushed and concurrent inputs never appear at the output.
- Assert rst_n=0 asynchronously mid-stream -> out_valid and out_state go to 0 without a clock edge. After release, the first new transaction produces the correct result at nominal latency.
